// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with in-order multi-entry retire
package rob_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
  } pci_t;

  typedef struct packed {
    pci_t            pc_info;
    logic [XLEN-1:0] data;
    logic            rdy;
  } sal2_t;
endpackage

module reorder_buffer
  import rob_pkg::*;
#(
  parameter int width      = XLEN,
  parameter int size       = 8,
  parameter int commit_max = 2,
  parameter int cdb_ports  = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic                                    enq_i,
  input  pci_t                                    enq_pci_i,
  output logic [$clog2(size)-1:0]                 enq_tag_o,
  output logic                                    full_o,
  output logic                                    empty_o,
  input  logic [cdb_ports-1:0]                    cdb_valid_i,
  input  logic [cdb_ports-1:0][$clog2(size)-1:0]  cdb_tag_i,
  input  logic [cdb_ports-1:0][width-1:0]         cdb_data_i,
  output logic                                    commit_o,
  output sal2_t [size-1:0]                        rdest_o,
  output logic [size-1:0][4:0]                    rd_bus_o
);
  localparam int TW = $clog2(size);
  localparam int PW = TW + 1;

  logic [size-1:0]  valid_q, valid_d, done_q, done_d;
  pci_t             pci_q [size];
  pci_t             pci_d [size];
  logic [width-1:0] data_q [size];
  logic [width-1:0] data_d [size];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic             commit_q, commit_d;
  sal2_t [size-1:0] rdest_q, rdest_d;

  logic [PW-1:0]    count;
  logic [PW-1:0]    k;
  logic             scan;
  logic [TW-1:0]    sel;
  logic [TW-1:0]    rsel;

  assign count     = tail_q - head_q;
  assign full_o    = (count == PW'(size));
  assign empty_o   = (count == '0);
  assign enq_tag_o = tail_q[TW-1:0];

  // Retire group length: contiguous done entries from head, stops at first not-done slot.
  always_comb begin
    k    = '0;
    scan = 1'b1;
    sel  = '0;
    for (int j = 0; j < commit_max; j++) begin
      sel = head_q[TW-1:0] + TW'(j);
      if (scan && valid_q[sel] && done_q[sel]) k = k + PW'(1);
      else scan = 1'b0;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    pci_d    = pci_q;
    data_d   = data_q;
    head_d   = head_q + k;
    tail_d   = tail_q;
    rdest_d  = '0;
    commit_d = (k != '0);
    rsel     = '0;

    for (int j = 0; j < commit_max; j++) begin
      rsel = head_q[TW-1:0] + TW'(j);
      if (PW'(j) < k) begin
        rdest_d[j].pc_info = pci_q[rsel];
        rdest_d[j].data    = XLEN'(data_q[rsel]);
        rdest_d[j].rdy     = 1'b1;
      end
    end

    if (enq_i && !full_o) begin
      valid_d[tail_q[TW-1:0]] = 1'b1;
      done_d[tail_q[TW-1:0]]  = 1'b0;
      pci_d[tail_q[TW-1:0]]   = enq_pci_i;
      data_d[tail_q[TW-1:0]]  = '0;
      tail_d                  = tail_q + PW'(1);
    end

    // Later ports overwrite earlier ones, so the highest index wins on a tag clash.
    for (int p = 0; p < cdb_ports; p++) begin
      if (cdb_valid_i[p] && valid_q[cdb_tag_i[p]]) begin
        data_d[cdb_tag_i[p]] = cdb_data_i[p];
        done_d[cdb_tag_i[p]] = 1'b1;
      end
    end

    for (int j = 0; j < commit_max; j++) begin
      rsel = head_q[TW-1:0] + TW'(j);
      if (PW'(j) < k) begin
        valid_d[rsel] = 1'b0;
        done_d[rsel]  = 1'b0;
      end
    end

    if (flush_i) begin
      valid_d  = '0;
      done_d   = '0;
      head_d   = '0;
      tail_d   = '0;
      rdest_d  = '0;
      commit_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      commit_q <= 1'b0;
      rdest_q  <= '0;
      for (int i = 0; i < size; i++) begin
        pci_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      pci_q    <= pci_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      commit_q <= commit_d;
      rdest_q  <= rdest_d;
    end
  end

  assign commit_o = commit_q;
  assign rdest_o  = rdest_q;

  always_comb begin
    rd_bus_o = '0;
    for (int j = 0; j < size; j++) begin
      if (rdest_q[j].rdy) rd_bus_o[j] = rdest_q[j].pc_info.rd;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order RV32I core. Dispatch allocates entries in program order and execution units complete them out of order over the CDB. The block retires up to `commit_max` contiguous completed entries per cycle from the head. It presents each retiring group on `commit`/`rdest`/`rd_bus` for the register file and the commit-checking scoreboard.

## Interface
- `width`, 32: data width of an entry's result.
- `size`, 8: number of entries; power of two, ≥ 4.
- `commit_max`, 2: maximum entries retired per cycle; 1 ≤ `commit_max` ≤ `size`.
- `cdb_ports`, 2: number of completion broadcast ports.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all entries (mispredict or exception).
- `enq`  in  1  allocate one entry this cycle; ignored when `full`.
- `enq_pci`  in  `pci_t`  decoded instruction info stored in the new entry.
- `enq_tag`  out  `$clog2(size)`  slot index the next `enq` will occupy (the current tail).
- `full`  out  1  all `size` entries valid.
- `empty`  out  1  no valid entries.
- `cdb_valid[cdb_ports]`  in  1 each  completion strobe.
- `cdb_tag[cdb_ports]`  in  `$clog2(size)` each  completing slot.
- `cdb_data[cdb_ports]`  in  `width` each  result value.
- `commit`  out  1  registered; high in any cycle where ≥1 entry is presented as retiring.
- `rdest[size]`  out  `sal2_t`  registered retire group; fields `pc_info`, `data`, `rdy`.
- `rd_bus[size]`  out  5 each  destination register of `rdest[i]`; 0 when `rdest[i].rdy` is 0.

## Operation
- State:
  - per slot: `valid`, `done`, `pci`, `data`;
  - `head` and `tail` pointers, each `$clog2(size)`+1 bits; the MSB is the wrap bit.
- `count` = `tail` − `head`.
  - `full` = (`count` == `size`).
  - `empty` = (`count` == 0).
  - `enq_tag` = `tail` low bits.
  - All three are combinational from registered state.
- Enqueue (`enq` & !`full`):
  - the slot at `tail` gets `valid`=1, `done`=0, `pci`=`enq_pci`, `data`=0;
  - `tail` increments by 1 with natural wrap.
- Completion: for each port with `cdb_valid` set, if slot `cdb_tag` is valid, write `data` and set `done`=1.
  - CDB to an invalid slot is ignored.
  - Two ports naming the same tag in one cycle: the higher port index wins.
- Retire selection (combinational, from registered state only):
  - k = number of consecutive slots starting at `head` with `valid` & `done`, capped at `commit_max`.
  - Scanning stops at the first slot not done. There is no out-of-order retire.
- On the edge where k > 0:
  - the k slots are cleared to `valid`=0, `done`=0;
  - `head` advances by k, wrapping.
- Output register, loaded every edge:
  - `rdest[j]` for j < k holds retiring entry j in program order (head first), with `rdy`=1.
  - `rdest[j]` for j ≥ k is all-zero.
  - `rd_bus[j]` = `rdest[j].pc_info.rd` when rdy, else 0.
  - `commit` = (k > 0).
- Entries without a destination (store, branch) retire identically. The consumer decides whether to write the register file.
- Flush: all `valid`/`done` cleared, `head`=`tail`=0, output register cleared. Flush overrides enqueue, completion and retire in the same cycle.
- Reset: same effect as flush, and also clears all `pci`/`data`.

## Timing
- Reset values:
  - `commit`=0;
  - all `rdest` entries and all `rd_bus` entries zero;
  - `empty`=1, `full`=0, `enq_tag`=0.
- Enqueue at edge t: the entry is visible from cycle t+1, and `enq_tag` advances in cycle t+1.
- CDB at edge t: the slot has `done` from cycle t+1. The earliest retire edge is t+1, so `rdest` shows the entry during cycle t+1→t+2.
- Minimum enqueue-to-commit-output latency: 2 edges (enq at t, CDB at t+1, retire at t+2, visible after t+2).
- `commit` is a level. Back-to-back retiring cycles keep it high, and `rdest` content changes each cycle.
- Full with simultaneous retire: `enq` is still refused that cycle, because `full` is computed before retire (no bypass). The freed slots are usable from the next cycle.
- Empty with simultaneous enq: a same-cycle CDB to that tag is ignored, because the slot is not yet valid.
- Wrap-around: a retire group may span slot `size`−1 to slot 0; the output order is still program order.
- Retire and CDB on the same cycle: a slot completing at edge t cannot retire at edge t.
- `rst` or `flush` asserted mid-group: `commit` is 0 in the following cycle.

## Test plan
- Reset, then idle 3 cycles → `commit`=0, `empty`=1, `enq_tag`=0, all `rdest.rdy`=0.
- Enqueue addi x1, addi x2, addi x3 (tags 0,1,2); CDB tag2=7, then tag0=5, then tag1=6 on successive cycles:
  - no commit until tag0 completes;
  - then `rdest[0]`={x1,5} alone;
  - next cycle `rdest[0]`={x2,6}, `rdest[1]`={x3,7}, `commit`=1.
- Enqueue 8 with no CDB → `full`=1 and a 9th `enq` is ignored. Complete tag0, then `enq` on the retire cycle → refused; accepted the next cycle at tag 0.
- Wrap: advance `head` to 7, enqueue two entries at tags 7 and 0, complete both → one group with `rdest[0]` from slot 7 and `rdest[1]` from slot 0.
- Four entries with all CDBs done, `flush` asserted on the edge retire would occur → `commit`=0 next cycle, `empty`=1, `enq_tag`=0.
- Two CDB ports hitting tag 3 simultaneously with values 10 (port0) and 20 (port1) → the entry retires with data 20.
